// File: rtl/approx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_pkg
// Purpose  : Shared types and default sizing for the approximate accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package approx_pkg;

  // Default sizing used by the accumulator and its adder row
  localparam int DEF_WIDTH       = 16;
  localparam int DEF_APPROX_BITS = 4;
  localparam int DEF_CNT_W       = 8;

  // Reduction control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/approx_add_row.sv
`default_nettype none
// ============================================================================
// Module   : approx_add_row
// Purpose  : Ripple adder whose low APPROX_BITS use a carry cell whose
//            carry-out ignores carry-in (a|b); remaining bits are exact.
// Revision : 1.0 - initial release
// ============================================================================

// Approximate cell: carry-out depends only on the local operand bits,
// which breaks the ripple chain through the low bits.
module approx_carry_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  logic g;

  // Propagate/generate form; p^g reduces to a|b
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    s  = p ^ ci;
    co = p ^ g;
  end
endmodule

// Conventional full adder for the exact high bits.
module exact_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  // Sum and majority carry
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end
endmodule

module approx_add_row #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  // c[i] is the carry into bit i; c[WIDTH] leaves the MSB
  logic [WIDTH:0] c;

  assign c[0] = 1'b0;
  assign cout = c[WIDTH];

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < APPROX_BITS) begin : g_approx
        approx_carry_cell u_cell (
          .a  (a[i]),
          .b  (b[i]),
          .ci (c[i]),
          .s  (s[i]),
          .co (c[i+1])
        );
      end else begin : g_exact
        exact_full_adder u_fa (
          .a  (a[i]),
          .b  (b[i]),
          .ci (c[i]),
          .s  (s[i]),
          .co (c[i+1])
        );
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/approx_accum_unit.sv
`default_nettype none
// ============================================================================
// Module   : approx_accum_unit
// Purpose  : Streaming reduction of len operands through an approximate
//            adder, with valid/ready on both sides and a sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module approx_accum_unit
  import approx_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_ovf_q, out_ovf_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             accept;
  logic             last_op;

  approx_add_row #(
    .WIDTH       (WIDTH),
    .APPROX_BITS (APPROX_BITS)
  ) u_add (
    .a    (acc_q),
    .b    (in_data),
    .s    (add_s),
    .cout (add_cout)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    accept  = in_ready_q & in_valid;
    last_op = (rem_q == CNT_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (len != '0) begin
            rem_d   = len;
            state_d = ST_LOAD;
          end else begin
            acc_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        // First operand seeds the accumulator without an add
        if (accept) begin
          acc_d   = in_data;
          rem_d   = rem_q - CNT_W'(1);
          state_d = last_op ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          acc_d = add_s;
          ovf_d = ovf_q | add_cout;
          rem_d = rem_q - CNT_W'(1);
          if (last_op) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are flop-driven
    in_ready_d  = (state_d == ST_LOAD) || (state_d == ST_ACC);
    out_valid_d = (state_d == ST_DONE);
    out_sum_d   = (state_d == ST_DONE) ? acc_d : '0;
    out_ovf_d   = (state_d == ST_DONE) ? ovf_d : 1'b0;
    busy_d      = (state_d != ST_IDLE);
  end

  // State, datapath and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_accum_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_approx_accum_unit
// Purpose  : Scoreboard bench for approx_accum_unit (WIDTH=16, APPROX_BITS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_accum_unit;

  localparam int W  = 16;
  localparam int AB = 4;
  localparam int CW = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_ovf;
  logic          busy;

  exp_t         sb[$];
  logic [W-1:0] ops_q[$];
  int           n_cmp;
  int           n_fail;
  bit           saw_in_ready;

  approx_accum_unit #(.WIDTH(W), .APPROX_BITS(AB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records whether in_ready was ever seen high
  always @(posedge clk) if (in_ready === 1'b1) saw_in_ready <= 1'b1;

  // Reference add: low bits carry a|b, high bits are a full adder
  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] s;
    logic         c;
    c = 1'b0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      if (i < AB) c = a[i] | b[i];
      else        c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return {c, s};
  endfunction

  // Expected result of reducing ops_q
  function automatic exp_t model_run();
    exp_t       e;
    logic [W:0] r;
    e.sum = '0;
    e.ovf = 1'b0;
    for (int i = 0; i < ops_q.size(); i++) begin
      if (i == 0) e.sum = ops_q[0];
      else begin
        r     = model_add(e.sum, ops_q[i]);
        e.sum = r[W-1:0];
        e.ovf = e.ovf | r[W];
      end
    end
    return e;
  endfunction

  task automatic start_run(input logic [CW-1:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers ops_q; optional toggling valid and a start pulse at edge inj
  task automatic feed(input bit toggle, input int inj, output int acc_n, output int edges);
    int idx;
    bit rdy;
    idx   = 0;
    acc_n = 0;
    edges = 0;
    while (idx < ops_q.size() && edges < 64) begin
      in_valid = toggle ? ((edges % 2) == 0) : 1'b1;
      in_data  = ops_q[idx];
      if (edges == inj) begin
        start = 1'b1;
        len   = 8'd5;
      end
      rdy = in_ready;
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (rdy && in_valid) begin
        idx++;
        acc_n++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int cyc, output bit ok);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < max) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = (out_valid === 1'b1);
  endtask

  // Waits for the result, captures it and completes the handshake
  task automatic take_result(output logic [W-1:0] s, output logic o, output bit ok);
    int cyc;
    wait_valid(40, cyc, ok);
    s = out_sum;
    o = out_ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_sum, out_ovf, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {in_ready, out_valid, out_sum, out_ovf, busy});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_approx_visible();
    int   acc_n, edges, cyc;
    bit   ok;
    exp_t e;
    ops_q = '{16'h0001, 16'h0002};
    sb.push_back(model_run());
    start_run(8'd2);
    feed(1'b0, -1, acc_n, edges);
    wait_valid(40, cyc, ok);
    n_cmp++;
    if (1 + edges + cyc !== 3 || !ok) begin
      n_fail++;
      $display("FAIL approx_latency: got %0d cycles required 3", 1 + edges + cyc);
    end
    e = sb.pop_front();
    n_cmp++;
    if (out_sum !== e.sum || out_sum !== 16'h0005) begin
      n_fail++;
      $display("FAIL approx_sum: got %h required %h", out_sum, e.sum);
    end
    n_cmp++;
    if (out_ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL approx_ovf: got %b required %b", out_ovf, e.ovf);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_approx_exact();
    int           acc_n, edges;
    bit           ok;
    logic [W-1:0] s;
    logic         o;
    exp_t         e;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) ops_q = '{16'h0007, 16'h0001};
      else        ops_q = '{16'h0100, 16'h0200};
      sb.push_back(model_run());
      start_run(8'd2);
      feed(1'b0, -1, acc_n, edges);
      take_result(s, o, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || s !== e.sum || o !== e.ovf) begin
        n_fail++;
        $display("FAIL exact_case%0d: got %h/%b required %h/%b", k, s, o, e.sum, e.ovf);
      end
    end
  endtask

  task automatic test_overflow_wrap();
    int           acc_n, edges;
    bit           ok;
    logic [W-1:0] s;
    logic         o;
    exp_t         e;
    ops_q = '{16'hFFF0, 16'h0010};
    sb.push_back(model_run());
    start_run(8'd2);
    feed(1'b0, -1, acc_n, edges);
    take_result(s, o, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || s !== e.sum || o !== 1'b1 || o !== e.ovf) begin
      n_fail++;
      $display("FAIL wrap_ovf: got %h/%b required %h/%b", s, o, e.sum, e.ovf);
    end
    ops_q = '{16'h1234};
    sb.push_back(model_run());
    start_run(8'd1);
    feed(1'b0, -1, acc_n, edges);
    take_result(s, o, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || s !== e.sum || o !== e.ovf) begin
      n_fail++;
      $display("FAIL ovf_cleared: got %h/%b required %h/%b", s, o, e.sum, e.ovf);
    end
  endtask

  task automatic test_zero_len();
    exp_t e;
    saw_in_ready = 1'b0;
    ops_q.delete();
    sb.push_back(model_run());
    start_run(8'd0);
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_sum !== e.sum || out_ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL zero_len: got v=%b %h/%b required v=1 %h/%b", out_valid, out_sum, out_ovf, e.sum, e.ovf);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (saw_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_ready: got %b required 0", saw_in_ready);
    end
  endtask

  task automatic test_handshake();
    int   acc_n, edges, cyc, extra;
    bit   ok;
    exp_t e;
    ops_q = '{16'h0010, 16'h0020, 16'h0040};
    sb.push_back(model_run());
    start_run(8'd3);
    feed(1'b1, 2, acc_n, edges);
    wait_valid(40, cyc, ok);
    e = sb.pop_front();
    extra = 0;
    // Hold out_ready low while offering a stray operand
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      if (in_ready === 1'b1) extra++;
      n_cmp++;
      if (!ok || out_valid !== 1'b1 || out_sum !== e.sum || out_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got v=%b %h/%b required v=1 %h/%b", i, out_valid, out_sum, out_ovf, e.sum, e.ovf);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (acc_n + extra !== 3 || e.sum !== 16'h0070) begin
      n_fail++;
      $display("FAIL accept_count: got %0d required 3", acc_n + extra);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL release: got v=%b busy=%b required 0/0", out_valid, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_acc_ignored: got busy=%b ready=%b required 0/0", busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int           acc_n, edges;
    bit           ok;
    logic [W-1:0] s;
    logic         o;
    exp_t         e;
    ops_q = '{16'h1111, 16'h2222};
    start_run(8'd4);
    feed(1'b0, -1, acc_n, edges);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_sum, out_ovf, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h required 0", {in_ready, out_valid, out_sum, out_ovf, busy});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: got v=%b busy=%b required 0/0", out_valid, busy);
    end
    ops_q = '{16'h00AA};
    sb.push_back(model_run());
    start_run(8'd1);
    feed(1'b0, -1, acc_n, edges);
    take_result(s, o, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || s !== e.sum || o !== e.ovf) begin
      n_fail++;
      $display("FAIL after_reset_run: got %h/%b required %h/%b", s, o, e.sum, e.ovf);
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    saw_in_ready = 1'b0;
    start        = 1'b0;
    len          = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    rst_n        = 1'b0;
    #1;
    test_reset();
    test_approx_visible();
    test_approx_exact();
    test_overflow_wrap();
    test_zero_len();
    test_handshake();
    test_reset_mid_run();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/approx_accum_unit.md
Name: approx_accum_unit

Overview:
- Sequential accumulator that consumes a stream of operands and sums them through an approximate ripple adder.
- Low bits use the team's approximate carry cell equation (carry-out independent of carry-in). High bits are exact.
- Sits downstream of the operand-fetch path. Its result feeds the processor writeback and reduction units through a valid/ready handshake.
- Used for low-power dot-product and sum reductions.

Parameters:
- WIDTH, 16: operand and sum width in bits.
- APPROX_BITS, 4: number of LSBs using the approximate carry. Range 0..WIDTH; 0 means a fully exact adder.
- CNT_W, 8: width of the operand-count field.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse that begins a reduction; sampled only in IDLE.
- len  in  CNT_W  number of operands to accumulate; sampled together with start.
- in_valid  in  1  operand valid.
- in_ready  out  1  unit accepts an operand.
- in_data  in  WIDTH  operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  accumulated result.
- out_ovf  out  1  sticky overflow flag; 1 if any add produced carry out of the MSB.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; acc, remaining, ovf cleared.
  - in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
  - Reset mid-operation abandons the reduction; nothing is emitted afterwards.
- Approximate add s = A(a,b), bit i:
  - i < APPROX_BITS: p=a^b, g=a&b; s_i = p ^ c_i; c_{i+1} = p ^ g (= a|b); c_0 = 0.
  - i >= APPROX_BITS: exact full adder; s_i = a^b^c_i; c_{i+1} = maj(a,b,c_i).
  - Carry out of bit WIDTH-1 is cout. The sum wraps modulo 2^WIDTH.
- FSM states: IDLE, LOAD, ACC, DONE.
  - IDLE: in_ready=0. On start with len!=0: remaining<=len, ovf<=0, go to LOAD. On start with len==0: acc<=0, ovf<=0, go to DONE.
  - LOAD: in_ready=1. On in_valid&in_ready: acc<=in_data (no add), remaining<=remaining-1. Go to DONE if remaining==1, else to ACC.
  - ACC: in_ready=1. On accept: acc<=A(acc,in_data), ovf<=ovf|cout, remaining--. Go to DONE when the accepted operand had remaining==1.
  - DONE: out_valid=1, out_sum=acc, out_ovf=ovf. Outputs hold stable while out_ready=0. On out_ready: go to IDLE, out_valid drops next cycle.
- Timing:
  - Latency is one cycle per accepted operand.
  - out_valid asserts the cycle after the last accept, or the cycle after start when len==0.
  - Throughput is one operand per cycle.
- start while not in IDLE is ignored.
- in_valid with in_ready=0 is ignored; no data is lost, the producer holds.
- out_sum and out_ovf are registered, with no combinational path from inputs.
- No operand is accepted in the same cycle as start.

Decomposition:
- Shared package approx_pkg holds:
  - state enum (IDLE, LOAD, ACC, DONE);
  - default WIDTH, APPROX_BITS and CNT_W constants.
- One combinational sub-module approx_add_row(WIDTH, APPROX_BITS): inputs a, b; outputs s, cout.
  - It instantiates the per-bit approximate cell for the low bits and exact full adders for the rest.
- The FSM, counter and registers stay in approx_accum_unit.

Test Plan (WIDTH=16, APPROX_BITS=4):
- Approximation visible: start len=2; operands 0x0001, 0x0002 -> out_sum=0x0005 (exact would be 0x0003), out_ovf=0, out_valid 3 cycles after start with continuous in_valid.
- Approximation matches exact: len=2; operands 0x0007, 0x0001 -> 0x0008. Then len=2; operands 0x0100, 0x0200 -> 0x0300.
- Overflow and wrap: len=2; operands 0xFFF0, 0x0010 -> out_sum=0x0000, out_ovf=1. A following reduction len=1, operand 0x1234 -> 0x1234, out_ovf=0.
- Zero length: start with len=0 -> out_valid the next cycle, out_sum=0, out_ovf=0, in_ready never asserted.
- Handshakes:
  - len=3 with in_valid toggling every other cycle and out_ready held low 5 cycles. Operands 0x0010, 0x0020, 0x0040 -> exactly 3 accepts, sum 0x0070.
  - Result holds stable until out_ready; busy drops after the handshake.
  - A start pulse asserted during ACC is ignored.
- Reset mid-run: len=4, assert rst_n=0 after 2 accepts -> all outputs 0 immediately. After release, a new len=1 run with operand 0x00AA -> 0x00AA.
